// File: rtl/alu_exec.sv
// alu_exec: registered integer execute unit with optional serial shifter.
// Single-cycle ALU ops; shifts take k cycles when SERIAL_SHIFT=1.
module alu_exec #(
  parameter bit SERIAL_SHIFT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  alu_control_in,
  input  logic [4:0]  shamt_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_out,
  output logic        overflow_out,
  output logic        zero_out
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nx;
  logic [31:0] work, work_nx;
  logic [4:0]  cnt, cnt_nx;
  logic        right, right_nx;
  logic        arith, arith_nx;
  logic        done_nx;
  logic [31:0] res_nx;
  logic        ovf_nx, zero_nx;

  logic        is_shift, is_var, is_right, is_arith;
  logic [4:0]  k;
  logic [31:0] sum, diff, alu_res, step;
  logic        alu_ovf;

  assign is_shift = (alu_control_in <= 5'd5);
  assign is_var   = alu_control_in inside {5'd3, 5'd4, 5'd5};
  assign is_right = alu_control_in inside {5'd1, 5'd2, 5'd4, 5'd5};
  assign is_arith = alu_control_in inside {5'd2, 5'd5};
  assign k        = is_var ? a_in[4:0] : shamt_in;
  assign sum      = a_in + b_in;
  assign diff     = a_in - b_in;
  assign busy     = (state == SHIFT);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_control_in)
      5'd0, 5'd3: alu_res = b_in << k;
      5'd1, 5'd4: alu_res = b_in >> k;
      5'd2, 5'd5: alu_res = $signed(b_in) >>> k;
      5'd6: begin
        alu_res = sum;
        alu_ovf = (a_in[31] == b_in[31]) && (sum[31] != a_in[31]);
      end
      5'd7:  alu_res = sum;
      5'd8: begin
        alu_res = diff;
        alu_ovf = (a_in[31] != b_in[31]) && (diff[31] != a_in[31]);
      end
      5'd9:  alu_res = diff;
      5'd10: alu_res = a_in & b_in;
      5'd11: alu_res = a_in | b_in;
      5'd12: alu_res = a_in ^ b_in;
      5'd13: alu_res = ~(a_in | b_in);
      5'd14: alu_res = {31'd0, $signed(a_in) < $signed(b_in)};
      5'd15: alu_res = {31'd0, a_in < b_in};
      5'd16: alu_res = {b_in[15:0], 16'h0};
      default: ;
    endcase
  end

  // One bit per cycle; arithmetic right shifts replicate the sign bit.
  assign step = right ? {arith & work[31], work[31:1]}
                      : {work[30:0], 1'b0};

  always_comb begin
    state_nx = state;
    work_nx  = work;
    cnt_nx   = cnt;
    right_nx = right;
    arith_nx = arith;
    done_nx  = 1'b0;
    res_nx   = result_out;
    ovf_nx   = overflow_out;
    zero_nx  = zero_out;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (SERIAL_SHIFT && is_shift && (k != 5'd0)) begin
            state_nx = SHIFT;
            work_nx  = b_in;
            cnt_nx   = k;
            right_nx = is_right;
            arith_nx = is_arith;
          end else begin
            done_nx = 1'b1;
            res_nx  = alu_res;
            ovf_nx  = alu_ovf;
            zero_nx = (alu_res == 32'd0);
          end
        end
      end
      SHIFT: begin
        work_nx = step;
        cnt_nx  = cnt - 5'd1;
        if (cnt == 5'd1) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          res_nx   = step;
          ovf_nx   = 1'b0;
          zero_nx  = (step == 32'd0);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      work         <= '0;
      cnt          <= '0;
      right        <= 1'b0;
      arith        <= 1'b0;
      done         <= 1'b0;
      result_out   <= '0;
      overflow_out <= 1'b0;
      zero_out     <= 1'b0;
    end else begin
      state        <= state_nx;
      work         <= work_nx;
      cnt          <= cnt_nx;
      right        <= right_nx;
      arith        <= arith_nx;
      done         <= done_nx;
      result_out   <= res_nx;
      overflow_out <= ovf_nx;
      zero_out     <= zero_nx;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed scoreboard bench for alu_exec.
// Serial-shift DUT is scoreboarded; a SERIAL_SHIFT=0 copy is checked alongside.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [4:0]  code, shamt;
  logic [31:0] a, b;

  logic        busy, done, ovf, zero;
  logic [31:0] res;
  logic        busy0, done0, ovf0, zero0;
  logic [31:0] res0;

  int passed = 0;
  int total  = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  alu_exec #(.SERIAL_SHIFT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_control_in(code), .shamt_in(shamt),
    .a_in(a), .b_in(b),
    .busy(busy), .done(done), .result_out(res),
    .overflow_out(ovf), .zero_out(zero)
  );

  alu_exec #(.SERIAL_SHIFT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_control_in(code), .shamt_in(shamt),
    .a_in(a), .b_in(b),
    .busy(busy0), .done(done0), .result_out(res0),
    .overflow_out(ovf0), .zero_out(zero0)
  );

  // Reference model: returns {overflow, result}.
  function automatic logic [32:0] model(
    input logic [4:0] c, input logic [31:0] x, y, input logic [4:0] s
  );
    logic [31:0] r;
    logic        o;
    longint      sx, sy, t;
    int          sh;
    r  = 32'd0;
    o  = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = (c >= 5'd3) ? int'(x[4:0]) : int'(s);
    case (c)
      5'd0, 5'd3: r = y << sh;
      5'd1, 5'd4: r = y >> sh;
      5'd2, 5'd5: begin
        r = y;
        for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      end
      5'd6, 5'd7, 5'd8, 5'd9: begin
        t = (c < 5'd8) ? sx + sy : sx - sy;
        r = t[31:0];
        if (c == 5'd6 || c == 5'd8)
          o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      5'd10: r = x & y;
      5'd11: r = x | y;
      5'd12: r = x ^ y;
      5'd13: r = ~(x | y);
      5'd14: r = (sx < sy) ? 32'd1 : 32'd0;
      5'd15: r = ({32'd0, x} < {32'd0, y}) ? 32'd1 : 32'd0;
      5'd16: r = {y[15:0], 16'h0000};
      default: r = 32'd0;
    endcase
    return {o, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic check_out(input string tag);
    logic [32:0] e;
    chk({tag, "/sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'd0;
    chk({tag, "/done"}, 32'(done), 32'd1);
    chk({tag, "/busy"}, 32'(busy), 32'd0);
    chk({tag, "/result"}, res, e[31:0]);
    chk({tag, "/ovf"}, 32'(ovf), 32'(e[32]));
    chk({tag, "/zero"}, 32'(zero), 32'(e[31:0] == 32'd0));
  endtask

  task automatic op(input logic [4:0] c, input logic [31:0] x, y,
                    input logic [4:0] s, input int lat, input string tag);
    logic [32:0] e;
    int n;
    e = model(c, x, y, s);
    code = c; a = x; b = y; shamt = s; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    chk({tag, "/c0_done"}, 32'(done0), 32'd1);
    chk({tag, "/c0_result"}, res0, e[31:0]);
    while (!done && n < 40) begin
      chk({tag, "/busy_wait"}, 32'(busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'(lat));
    check_out(tag);
    @(negedge clk);
    chk({tag, "/single_pulse"}, 32'(done), 32'd0);
    chk({tag, "/held"}, res, e[31:0]);
  endtask

  initial begin
    int n;
    logic seen;
    logic [32:0] e_sra, e_add;

    rst_n = 1'b0; start = 1'b1; code = 5'd6;
    a = 32'h7FFF_FFFF; b = 32'd1; shamt = 5'd0;
    repeat (2) @(negedge clk);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/result", res, 32'd0);
    chk("rst/ovf", 32'(ovf), 32'd0);
    chk("rst/zero", 32'(zero), 32'd0);
    chk("rst/c0_done", 32'(done0), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle/done", 32'(done), 32'd0);
    chk("idle/result", res, 32'd0);

    op(5'd6, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, "add_ovf");
    op(5'd7, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, "addu");
    op(5'd8, 32'h8000_0000, 32'd1, 5'd0, 0, "sub_ovf");
    op(5'd9, 32'h0000_0005, 32'd7, 5'd0, 0, "subu");
    op(5'd13, 32'h0F0F_0000, 32'h00F0_00FF, 5'd0, 0, "nor");
    op(5'd12, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0, 0, "xor");

    // sra by 4; add requests during busy are dropped, the one in the done cycle is taken.
    e_sra = model(5'd2, 32'h0, 32'hF000_0000, 5'd4);
    e_add = model(5'd6, 32'd5, 32'd6, 5'd0);
    chk("sra/model", e_sra[31:0], 32'hFF00_0000);
    code = 5'd2; a = 32'h0; b = 32'hF000_0000; shamt = 5'd4; start = 1'b1;
    exp_q.push_back(e_sra);
    @(negedge clk);
    code = 5'd6; a = 32'd5; b = 32'd6; shamt = 5'd0; start = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      chk("sra/busy", 32'(busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk("sra/latency", 32'(n), 32'd4);
    check_out("sra");
    exp_q.push_back(e_add);
    @(negedge clk);
    start = 1'b0;
    check_out("add_in_done_cycle");
    @(negedge clk);
    chk("add_in_done_cycle/single", 32'(done), 32'd0);

    op(5'd4, 32'h0000_0023, 32'h0000_0080, 5'd0, 3, "srlv");
    op(5'd3, 32'h0000_0020, 32'hDEAD_BEEF, 5'd0, 0, "sllv_v0");
    op(5'd0, 32'h0, 32'h0000_0001, 5'd31, 31, "sll31");
    op(5'd5, 32'h0000_0001, 32'h8000_0001, 5'd0, 1, "srav1");
    op(5'd14, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0, "slt");
    op(5'd15, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0, "sltu");
    op(5'd16, 32'h0, 32'h0000_1234, 5'd0, 0, "lui");
    op(5'd21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0, "undef");
    op(5'd11, 32'h1200_0000, 32'h0000_0034, 5'd0, 0, "or");

    // Reset in the middle of a long shift: no done, outputs cleared.
    code = 5'd0; a = 32'h0; b = 32'd1; shamt = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      chk("abort/busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort/busy_clr", 32'(busy), 32'd0);
    chk("abort/result", res, 32'd0);
    chk("abort/zero", 32'(zero), 32'd0);
    chk("abort/ovf", 32'(ovf), 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("abort/no_done", 32'(seen), 32'd0);
    chk("abort/result_held", res, 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
